i2c_slave_fsm: RTL and testbench
================================

Name: i2c_slave_fsm

Overview:
Target-side (responder) I2C byte engine that answers the i2c_master_fsm on the same open-drain SCL/SDA bus.
- Synchronises SCL/SDA into i_clk and detects START/STOP.
- Receives and compares the 7-bit address, ACKs on a match.
- Delivers written bytes to the user side, or fetches read bytes from it and shifts them out.
- Never drives SCL; clock stretching is not supported.

Parameters:
- ADDR, 7'h50, 7-bit target address this block responds to.
- SYNC_STAGES, 2, flip-flop depth of the SCL/SDA input synchronisers (minimum 2).

Ports:
- i_clk  input  1  system clock (oversamples SCL by at least 8x).
- i_rst_n  input  1  asynchronous active-low reset.
- i_scl  input  1  SCL read back from tristate_port.
- i_sda  input  1  SDA read back from tristate_port.
- o_sda  output  1  SDA drive into tristate_port: 0 = pull low, 1 = release.
- i_input  input  8  read data from user; sampled on the SCL fall that ends a read ACK slot.
- o_output  output  8  last byte written by the master.
- o_nextbyte  output  1  1-cycle strobe: o_output holds a new byte.
- o_rdreq  output  1  1-cycle strobe: user must present the next read byte on i_input.
- o_active  output  1  high while addressed (from address match until STOP/START).
- o_rw  output  1  R/W bit of the current transfer (1 = master reads).
- o_nack  output  1  1-cycle strobe: master NACKed a read byte.

Behaviour:
Reset:
- Reset is asynchronous; on assertion o_sda=1 immediately.
- All other outputs and the shift register reset to 0; synchroniser flops reset to 1; state = IDLE.

Bus events (computed on synchronised signals, 1-cycle registered edge detect):
- START = SDA fall while SCL high.
- STOP = SDA rise while SCL high.
- SCL rise = sample point. SCL fall = drive-change point.

Event priority:
- STOP in any state -> IDLE, o_sda=1, o_active=0.
- START in any state (including repeated START) -> ADDR, bit counter=0, o_sda=1, o_active=0.
- START/STOP take precedence over any SCL edge detected in the same cycle.

States:
- IDLE: o_sda=1; wait for START.
- ADDR: shift SDA MSB-first on each of 8 SCL rises.
  - After the 8th rise: if shift[7:1]==ADDR, latch o_rw=shift[0] and go to ADDR_ACK; else go to IGNORE.
- ADDR_ACK:
  - On the next SCL fall: o_sda=0, o_active=1.
  - If o_rw=1: pulse o_rdreq on the ACK-slot SCL rise.
  - On the SCL fall ending the slot: if o_rw=0, release SDA and go to WR_DATA; if o_rw=1, load i_input, drive bit7 and go to RD_DATA.
- WR_DATA: shift 8 bits on SCL rises.
  - One cycle after the 8th rise: o_output=shift, pulse o_nextbyte.
  - Go to WR_ACK.
- WR_ACK: drive SDA low from the next SCL fall until the following SCL fall, then release and return to WR_DATA.
  - Every write byte is ACKed; no overflow or back-pressure.
- RD_DATA: on each SCL fall, drive the next bit MSB-first (bit7 is already on the bus).
  - After the 8th bit's SCL fall, release SDA and go to RD_ACK.
- RD_ACK: sample SDA at the SCL rise.
  - SDA=0 (ACK): pulse o_rdreq at that rise; on the next SCL fall load i_input, drive bit7, go to RD_DATA.
  - SDA=1 (NACK): pulse o_nack, keep SDA released, go to IGNORE.
- IGNORE: o_sda=1; leave only on START/STOP.

Counters and timing:
- Bit counter is 3 bits; it wraps 7->0 at each byte boundary.
- User latency for reads: i_input must be valid within half an SCL period of o_rdreq.

Reset mid-transfer:
- SDA is released asynchronously.
- After reset release the block stays in IDLE until a fresh START; any byte in progress is lost silently.

Decomposition:
- Package i2c_pkg holds:
  - the state encoding (IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE);
  - SDA_RELEASE=1 and SDA_DRIVE_LOW=0;
  - BYTE_BITS=8.
- One sub-module, i2c_bus_sync, containing:
  - SYNC_STAGES-deep synchronisers for SCL/SDA;
  - registered previous values;
  - 1-cycle outputs scl_rise, scl_fall, start_det, stop_det, plus synced scl and sda.
- The FSM, shift register and bit counter live in i2c_slave_fsm.

Test Plan:
1. Write 0x50+W, then 0xA5, then STOP -> SDA low in both ACK slots; o_output=8'hA5 with one o_nextbyte pulse; o_rw=0; o_active falls at STOP.
2. Address 0x51+W, then byte 0xFF -> SDA never driven low (o_sda stays 1); o_nextbyte never pulses; o_active stays 0.
3. Read 0x50+R with user i_input=8'h3C then 8'hC3; master ACKs byte 1 and NACKs byte 2 -> SDA carries 00111100 then 11000011; two o_rdreq pulses; one o_nack pulse; SDA released after the NACK.
4. Write 0x50+W and 0x12, then repeated START with 0x50+R and i_input=8'h77, then NACK and STOP -> o_output=8'h12; o_rw switches to 1; bus carries 0x77.
5. Assert i_rst_n=0 while the target holds SDA low in ADDR_ACK -> o_sda=1 in the same cycle; all outputs 0. After release, a byte 0xAA clocked without a START is ignored.
6. STOP after only 4 data bits of a write -> state goes to IDLE; no o_nextbyte pulse; a following 0x50+W transfer is ACKed normally.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target engine.
//   - FSM state encoding
//   - open-drain SDA drive levels
//   - byte width and the bus-event bundle produced by i2c_bus_sync
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_DATA,
        ST_RD_ACK,
        ST_IGNORE
    } i2c_state_e;

    localparam logic SDA_RELEASE   = 1'b1;
    localparam logic SDA_DRIVE_LOW = 1'b0;
    localparam int   BYTE_BITS     = 8;

    // Synchronised bus levels plus single-cycle event strobes.
    typedef struct packed {
        logic scl;
        logic sda;
        logic scl_rise;
        logic scl_fall;
        logic start_det;
        logic stop_det;
    } bus_evt_t;

    // True when the 3-bit counter sits on the last bit of a byte.
    function automatic logic last_bit(input logic [2:0] cnt);
        return cnt == 3'(BYTE_BITS - 1);
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA input conditioning for the I2C target.
//   i_clk, i_rst_n : system clock, async active-low reset
//   i_scl, i_sda   : raw bus levels
//   o_evt          : synced scl/sda plus 1-cycle scl_rise, scl_fall,
//                    start_det, stop_det
module i2c_bus_sync
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic     i_clk,
    input  logic     i_rst_n,
    input  logic     i_scl,
    input  logic     i_sda,
    output bus_evt_t o_evt
);

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_prev_q, scl_prev_d;
    logic                   sda_prev_q, sda_prev_d;
    logic                   scl_s, sda_s;

    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], i_scl};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], i_sda};
        scl_s      = scl_sync_q[SYNC_STAGES-1];
        sda_s      = sda_sync_q[SYNC_STAGES-1];
        scl_prev_d = scl_s;
        sda_prev_d = sda_s;
    end

    // Everything resets to the idle-bus level so that reset release on an
    // idle bus produces no spurious edges.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
        end
    end

    // START/STOP need SCL high on both sides of the SDA edge so that an SDA
    // change coinciding with an SCL edge is not mistaken for a bus condition.
    always_comb begin
        o_evt.scl       = scl_s;
        o_evt.sda       = sda_s;
        o_evt.scl_rise  = scl_s & ~scl_prev_q;
        o_evt.scl_fall  = ~scl_s & scl_prev_q;
        o_evt.start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
        o_evt.stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    end

endmodule

// File: rtl/i2c_slave_fsm.sv
// I2C target byte engine (no clock stretching, never drives SCL).
//   i_clk, i_rst_n : system clock (>= 8x SCL), async active-low reset
//   i_scl, i_sda   : bus levels read back from the pad
//   o_sda          : 0 = pull SDA low, 1 = release
//   i_input        : read byte from user, sampled on the SCL fall ending a
//                    read ACK slot
//   o_output       : last byte written by the master
//   o_nextbyte     : strobe, o_output holds a new byte
//   o_rdreq        : strobe, present the next read byte on i_input
//   o_active       : addressed (address match until STOP/START)
//   o_rw           : R/W bit of the current transfer (1 = master reads)
//   o_nack         : strobe, master NACKed a read byte
module i2c_slave_fsm
    import i2c_pkg::*;
#(
    parameter logic [6:0] ADDR        = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_scl,
    input  logic                 i_sda,
    output logic                 o_sda,
    input  logic [BYTE_BITS-1:0] i_input,
    output logic [BYTE_BITS-1:0] o_output,
    output logic                 o_nextbyte,
    output logic                 o_rdreq,
    output logic                 o_active,
    output logic                 o_rw,
    output logic                 o_nack
);

    bus_evt_t evt;

    i2c_bus_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_scl  (i_scl),
        .i_sda  (i_sda),
        .o_evt  (evt)
    );

    // The FSM works purely on SCL edges; the synced level is not needed.
    logic unused_scl;
    assign unused_scl = evt.scl;

    i2c_state_e           state_q, state_d;
    logic [BYTE_BITS-1:0] shift_q, shift_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    // Second-half marker inside ACK slots: set once the slot has started
    // (ADDR_ACK/WR_ACK: SDA pulled low; RD_ACK: master ACK seen).
    logic                 ack_q, ack_d;
    logic                 sda_q, sda_d;
    logic                 active_q, active_d;
    logic                 rw_q, rw_d;
    logic [BYTE_BITS-1:0] output_q, output_d;
    logic                 nextbyte_q, nextbyte_d;
    logic                 rdreq_q, rdreq_d;
    logic                 nack_q, nack_d;

    logic [BYTE_BITS-1:0] shift_in;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        ack_d      = ack_q;
        sda_d      = sda_q;
        active_d   = active_q;
        rw_d       = rw_q;
        output_d   = output_q;
        nextbyte_d = 1'b0;
        rdreq_d    = 1'b0;
        nack_d     = 1'b0;
        shift_in   = {shift_q[BYTE_BITS-2:0], evt.sda};

        if (evt.stop_det) begin
            state_d  = ST_IDLE;
            sda_d    = SDA_RELEASE;
            active_d = 1'b0;
            ack_d    = 1'b0;
        end else if (evt.start_det) begin
            state_d   = ST_ADDR;
            bit_cnt_d = '0;
            sda_d     = SDA_RELEASE;
            active_d  = 1'b0;
            ack_d     = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    sda_d = SDA_RELEASE;
                end

                ST_ADDR: begin
                    if (evt.scl_rise) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (last_bit(bit_cnt_q)) begin
                            if (shift_in[7:1] == ADDR) begin
                                rw_d    = shift_in[0];
                                ack_d   = 1'b0;
                                state_d = ST_ADDR_ACK;
                            end else begin
                                state_d = ST_IGNORE;
                            end
                        end
                    end
                end

                ST_ADDR_ACK: begin
                    if (!ack_q) begin
                        if (evt.scl_fall) begin
                            sda_d    = SDA_DRIVE_LOW;
                            active_d = 1'b1;
                            ack_d    = 1'b1;
                        end
                    end else begin
                        if (evt.scl_rise && rw_q) rdreq_d = 1'b1;
                        if (evt.scl_fall) begin
                            ack_d     = 1'b0;
                            bit_cnt_d = '0;
                            if (rw_q) begin
                                shift_d = i_input;
                                sda_d   = i_input[BYTE_BITS-1];
                                state_d = ST_RD_DATA;
                            end else begin
                                sda_d   = SDA_RELEASE;
                                state_d = ST_WR_DATA;
                            end
                        end
                    end
                end

                ST_WR_DATA: begin
                    if (evt.scl_rise) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (last_bit(bit_cnt_q)) begin
                            output_d   = shift_in;
                            nextbyte_d = 1'b1;
                            ack_d      = 1'b0;
                            state_d    = ST_WR_ACK;
                        end
                    end
                end

                ST_WR_ACK: begin
                    if (evt.scl_fall) begin
                        if (!ack_q) begin
                            sda_d = SDA_DRIVE_LOW;
                            ack_d = 1'b1;
                        end else begin
                            sda_d     = SDA_RELEASE;
                            ack_d     = 1'b0;
                            bit_cnt_d = '0;
                            state_d   = ST_WR_DATA;
                        end
                    end
                end

                // bit_cnt counts bits already shifted out; bit7 went on the
                // bus when the byte was loaded.
                ST_RD_DATA: begin
                    if (evt.scl_fall) begin
                        if (last_bit(bit_cnt_q)) begin
                            sda_d     = SDA_RELEASE;
                            bit_cnt_d = '0;
                            ack_d     = 1'b0;
                            state_d   = ST_RD_ACK;
                        end else begin
                            shift_d   = {shift_q[BYTE_BITS-2:0], 1'b0};
                            sda_d     = shift_q[BYTE_BITS-2];
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end

                ST_RD_ACK: begin
                    if (!ack_q) begin
                        if (evt.scl_rise) begin
                            if (!evt.sda) begin
                                rdreq_d = 1'b1;
                                ack_d   = 1'b1;
                            end else begin
                                nack_d  = 1'b1;
                                state_d = ST_IGNORE;
                            end
                        end
                    end else if (evt.scl_fall) begin
                        shift_d   = i_input;
                        sda_d     = i_input[BYTE_BITS-1];
                        ack_d     = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = ST_RD_DATA;
                    end
                end

                ST_IGNORE: begin
                    sda_d = SDA_RELEASE;
                end

                default: begin
                    state_d = ST_IDLE;
                    sda_d   = SDA_RELEASE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            ack_q      <= 1'b0;
            sda_q      <= SDA_RELEASE;
            active_q   <= 1'b0;
            rw_q       <= 1'b0;
            output_q   <= '0;
            nextbyte_q <= 1'b0;
            rdreq_q    <= 1'b0;
            nack_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            ack_q      <= ack_d;
            sda_q      <= sda_d;
            active_q   <= active_d;
            rw_q       <= rw_d;
            output_q   <= output_d;
            nextbyte_q <= nextbyte_d;
            rdreq_q    <= rdreq_d;
            nack_q     <= nack_d;
        end
    end

    assign o_sda      = sda_q;
    assign o_output   = output_q;
    assign o_nextbyte = nextbyte_q;
    assign o_rdreq    = rdreq_q;
    assign o_active   = active_q;
    assign o_rw       = rw_q;
    assign o_nack     = nack_q;

endmodule

// File: tb/tb_i2c_slave_fsm.sv
module tb_i2c_slave_fsm;

    localparam logic [6:0] ADDR = 7'h50;
    localparam int         Q    = 4;   // quarter SCL period in i_clk cycles

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic       m_scl, m_sda;
    logic       bus_sda;
    logic       o_sda;
    logic [7:0] i_input;
    logic [7:0] o_output;
    logic       o_nextbyte, o_rdreq, o_active, o_rw, o_nack;

    // Open-drain wired-AND of master and target.
    assign bus_sda = m_sda & o_sda;

    always #5 i_clk = ~i_clk;

    i2c_slave_fsm #(.ADDR(ADDR), .SYNC_STAGES(2)) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_scl     (m_scl),
        .i_sda     (bus_sda),
        .o_sda     (o_sda),
        .i_input   (i_input),
        .o_output  (o_output),
        .o_nextbyte(o_nextbyte),
        .o_rdreq   (o_rdreq),
        .o_active  (o_active),
        .o_rw      (o_rw),
        .o_nack    (o_nack)
    );

    // Strobe / drive-low counters.
    int nb_cnt = 0, rq_cnt = 0, nk_cnt = 0, low_cnt = 0;
    always @(posedge i_clk) begin
        if (o_nextbyte) nb_cnt <= nb_cnt + 1;
        if (o_rdreq)    rq_cnt <= rq_cnt + 1;
        if (o_nack)     nk_cnt <= nk_cnt + 1;
        if (!o_sda)     low_cnt <= low_cnt + 1;
    end

    int chk_cnt = 0, pass_cnt = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    typedef struct {
        logic [6:0]      addr;
        logic            rw;
        int              n;
        logic [2:0][7:0] d;       // d[0] is the first byte
        bit              stop;
        logic            exp_ack; // 0 = target ACKs
        logic [7:0]      exp_out;
        int              exp_nb;
        int              exp_rq;
        int              exp_nk;
    } txn_t;

    function automatic txn_t mk(logic [6:0] a, logic rw, int n, logic [23:0] d, bit stop,
                                logic ack, logic [7:0] out, int nb, int rq, int nk);
        txn_t t;
        t.addr = a; t.rw = rw; t.n = n; t.d = d; t.stop = stop;
        t.exp_ack = ack; t.exp_out = out; t.exp_nb = nb; t.exp_rq = rq; t.exp_nk = nk;
        return t;
    endfunction

    // Transaction-level reference: a matched write ACKs every byte and delivers
    // each one; a matched read costs one request per byte and ends in one NACK.
    function automatic txn_t model(txn_t t, logic [7:0] prev_out);
        txn_t r = t;
        logic match = (t.addr == ADDR);
        r.exp_ack = !match;
        r.exp_nb  = (match && !t.rw) ? t.n : 0;
        r.exp_out = (match && !t.rw) ? t.d[t.n-1] : prev_out;
        r.exp_rq  = (match && t.rw) ? t.n : 0;
        r.exp_nk  = (match && t.rw) ? 1 : 0;
        return r;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic clock_bit(input logic b, output logic r);
        m_sda = b;  tick(Q);
        m_scl = 1'b1; tick(Q);
        r = bus_sda; tick(Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic send_byte(input logic [7:0] v, output logic ack);
        logic dummy;
        for (int i = 7; i >= 0; i--) clock_bit(v[i], dummy);
        clock_bit(1'b1, ack);
    endtask

    task automatic recv_byte(output logic [7:0] v);
        for (int i = 7; i >= 0; i--) clock_bit(1'b1, v[i]);
    endtask

    task automatic start_cond();
        m_sda = 1'b1; tick(Q);
        m_scl = 1'b1; tick(Q);
        m_sda = 1'b0; tick(Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic stop_cond();
        m_sda = 1'b0; tick(Q);
        m_scl = 1'b1; tick(Q);
        m_sda = 1'b1; tick(2*Q);
    endtask

    task automatic run_txn(input txn_t t);
        int nb0, rq0, nk0, lo0;
        logic a;
        logic [7:0] b;
        nb0 = nb_cnt; rq0 = rq_cnt; nk0 = nk_cnt; lo0 = low_cnt;
        i_input = t.d[0];
        start_cond();
        send_byte({t.addr, t.rw}, a);
        check("addr_ack", a, t.exp_ack);
        check("active", o_active, !t.exp_ack);
        if (!t.exp_ack) check("rw", o_rw, t.rw);
        for (int i = 0; i < t.n; i++) begin
            if (!t.rw) begin
                send_byte(t.d[i], a);
                check("wr_ack", a, t.exp_ack);
            end else begin
                recv_byte(b);
                check("rd_byte", b, t.exp_ack ? 8'hFF : t.d[i]);
                if (i < t.n - 1) i_input = t.d[i+1];
                clock_bit(i == t.n - 1, a);
                if (i == t.n - 1) check("nack_release", o_sda, 1'b1);
            end
        end
        if (t.stop) stop_cond();
        check("nextbyte_cnt", nb_cnt - nb0, t.exp_nb);
        check("rdreq_cnt", rq_cnt - rq0, t.exp_rq);
        check("nack_cnt", nk_cnt - nk0, t.exp_nk);
        check("output", o_output, t.exp_out);
        if (t.exp_ack) check("never_low", low_cnt - lo0, 0);
        if (t.stop) check("active_stop", o_active, 1'b0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        txn_t tbl[$];
        txn_t t;
        logic [7:0] model_out;
        logic a;
        int nb0, lo0;
        logic [3:0] part;

        m_scl = 1'b1; m_sda = 1'b1; i_input = 8'h00; i_rst_n = 1'b0;
        tick(3);
        check("rst_sda", o_sda, 1'b1);
        check("rst_outs", {o_active, o_rw, o_nextbyte, o_rdreq, o_nack, o_output}, 0);
        i_rst_n = 1'b1;
        tick(4);

        // addr, rw, n, bytes{d2,d1,d0}, stop, ack, out, nb, rq, nk
        tbl.push_back(mk(7'h50, 1'b0, 1, 24'h0000A5, 1, 1'b0, 8'hA5, 1, 0, 0));
        tbl.push_back(mk(7'h51, 1'b0, 1, 24'h0000FF, 1, 1'b1, 8'hA5, 0, 0, 0));
        tbl.push_back(mk(7'h50, 1'b1, 2, 24'h00C33C, 1, 1'b0, 8'hA5, 0, 2, 1));
        tbl.push_back(mk(7'h50, 1'b0, 1, 24'h000012, 0, 1'b0, 8'h12, 1, 0, 0));
        tbl.push_back(mk(7'h50, 1'b1, 1, 24'h000077, 1, 1'b0, 8'h12, 0, 1, 1));
        tbl.push_back(mk(7'h50, 1'b0, 2, 24'h008001, 1, 1'b0, 8'h80, 2, 0, 0));
        tbl.push_back(mk(7'h2A, 1'b1, 1, 24'h00005E, 1, 1'b1, 8'h80, 0, 0, 0));
        foreach (tbl[i]) run_txn(tbl[i]);

        model_out = 8'h80;
        for (int k = 0; k < 20; k++) begin
            t.addr = ($urandom_range(0, 1) != 0) ? ADDR : 7'($urandom);
            t.rw   = 1'($urandom);
            t.n    = $urandom_range(1, 3);
            t.d    = 24'($urandom);
            t.stop = ($urandom_range(0, 3) != 0);
            t = model(t, model_out);
            model_out = t.exp_out;
            run_txn(t);
        end

        // Reset while the target holds SDA low in the address ACK slot.
        start_cond();
        for (int i = 7; i >= 0; i--) begin
            logic [7:0] av;
            av = {ADDR, 1'b0};
            clock_bit(av[i], a);
        end
        m_sda = 1'b1;
        tick(Q);
        check("ack_driving", o_sda, 1'b0);
        i_rst_n = 1'b0;
        #1;
        check("async_rst_sda", o_sda, 1'b1);
        check("async_rst_outs", {o_active, o_rw, o_nextbyte, o_rdreq, o_nack, o_output}, 0);
        tick(2);
        i_rst_n = 1'b1;
        tick(4);
        nb0 = nb_cnt; lo0 = low_cnt;
        send_byte(8'hAA, a);
        check("no_start_ack", a, 1'b1);
        check("no_start_nb", nb_cnt - nb0, 0);
        check("no_start_low", low_cnt - lo0, 0);
        check("no_start_active", o_active, 1'b0);
        stop_cond();

        // STOP after four data bits of a write.
        nb0 = nb_cnt;
        start_cond();
        send_byte({ADDR, 1'b0}, a);
        check("abort_addr_ack", a, 1'b0);
        part = 4'b1011;
        for (int i = 3; i >= 0; i--) begin
            logic r;
            clock_bit(part[i], r);
        end
        stop_cond();
        check("abort_nb", nb_cnt - nb0, 0);
        check("abort_active", o_active, 1'b0);
        check("abort_output", o_output, 8'h00);
        run_txn(mk(ADDR, 1'b0, 1, 24'h00005A, 1, 1'b0, 8'h5A, 1, 0, 0));

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
